dp32_seq: RTL and testbench

Vector dot-product sequencer wrapped around one dp32 SIMD multiplier/adder instance. It accepts a start command with precision mode and vector length, then pulls operand word pairs over a valid/ready stream. Each dp32 lane-sum is accumulated into a wide register, and the final result is presented on a valid/ready output port. It sits between the operand-fetch logic and the writeback stage, and time-shares the single dp32 across multi-word vectors.

---
 rtl/dp32_seq.sv | 150 +++++++++++++++
 tb/tb_dp32_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dp32_seq.sv
// Vector dot-product sequencer: streams operand word pairs through one dp32
// SIMD multiply/add unit and accumulates the lane sums into a wide result.

module dp32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] mul_int32,
  output logic [32:0] sum_int16,
  output logic [17:0] sum_int8,
  output logic [10:0] sum_int4,
  output logic [7:0]  sum_int2
);
  // Each lane product is widened to the sum width before multiplying, so no
  // intermediate term can overflow.
  always_comb begin
    mul_int32 = 64'(a) * 64'(b);
    sum_int16 = '0;
    sum_int8  = '0;
    sum_int4  = '0;
    sum_int2  = '0;
    for (int i = 0; i < 2; i++)
      sum_int16 = sum_int16 + 33'(a[i*16 +: 16]) * 33'(b[i*16 +: 16]);
    for (int i = 0; i < 4; i++)
      sum_int8 = sum_int8 + 18'(a[i*8 +: 8]) * 18'(b[i*8 +: 8]);
    for (int i = 0; i < 8; i++)
      sum_int4 = sum_int4 + 11'(a[i*4 +: 4]) * 11'(b[i*4 +: 4]);
    for (int i = 0; i < 16; i++)
      sum_int2 = sum_int2 + 8'(a[i*2 +: 2]) * 8'(b[i*2 +: 2]);
  end
endmodule

module dp32_seq #(
  parameter int ACC_W = 64,
  parameter int LEN_W = 16
) (
  input  logic             CLK,
  input  logic             nrst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] count;
  logic [2:0]       mode_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             pend;

  logic [63:0]      mul_int32;
  logic [32:0]      sum_int16;
  logic [17:0]      sum_int8;
  logic [10:0]      sum_int4;
  logic [7:0]       sum_int2;
  logic [ACC_W-1:0] lane_sum;
  logic [ACC_W-1:0] acc_sum;
  logic             accept;

  dp32 u_dp32 (
    .a         (a_q),
    .b         (b_q),
    .mul_int32 (mul_int32),
    .sum_int16 (sum_int16),
    .sum_int8  (sum_int8),
    .sum_int4  (sum_int4),
    .sum_int2  (sum_int2)
  );

  always_comb begin
    lane_sum = '0;
    case (mode_q)
      3'd0:    lane_sum = ACC_W'(mul_int32);
      3'd1:    lane_sum = ACC_W'(sum_int16);
      3'd2:    lane_sum = ACC_W'(sum_int8);
      3'd3:    lane_sum = ACC_W'(sum_int4);
      3'd4:    lane_sum = ACC_W'(sum_int2);
      default: lane_sum = '0;
    endcase
  end

  assign acc_sum  = acc + lane_sum;
  // Handshake outputs depend only on registered state, never on in_valid/out_ready.
  assign in_ready = (state == RUN) && (count != '0);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      mode_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= (mode > 3'd4) ? 3'd0 : mode;
            count  <= len;
            acc    <= '0;
            pend   <= 1'b0;
            if (len == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= '0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            count <= count - {{(LEN_W-1){1'b0}}, 1'b1};
          end
          if (pend) acc <= acc_sum;
          pend <= accept;
          // With count at zero no accept can overlap, so this is the final term.
          if (pend && (count == '0)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= acc_sum;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dp32_seq.sv
// Scoreboard bench for dp32_seq: expected dot products are queued at command
// time and compared when the result handshake completes.

module tb_dp32_seq;
  localparam int ACC_W = 64;
  localparam int LEN_W = 16;

  logic             CLK = 1'b0;
  logic             nrst = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       mode = '0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      a = '0;
  logic [31:0]      b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] result;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;
  logic [ACC_W-1:0] exp_q[$];

  dp32_seq #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .CLK       (CLK),
    .nrst      (nrst),
    .start     (start),
    .mode      (mode),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  // Generic lane model: split both words into equal unsigned lanes and sum products.
  function automatic logic [ACC_W-1:0] model(input logic [2:0] m, input logic [31:0] x, input logic [31:0] y);
    int mm;
    int w;
    logic [31:0] mask;
    logic [63:0] xl, yl;
    logic [ACC_W-1:0] s;
    mm = (m > 3'd4) ? 0 : int'(m);
    w = 32 >> mm;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    s = '0;
    for (int i = 0; i < 32 / w; i++) begin
      xl = 64'((x >> (i * w)) & mask);
      yl = 64'((y >> (i * w)) & mask);
      s = s + ACC_W'(xl * yl);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (nrst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 64'(exp_q.size()), 64'd1);
      else chk("result", result, exp_q.pop_front());
    end
  end

  task automatic run_vec(input string tag, input logic [2:0] m, input int n,
                         input logic [31:0] x, input logic [31:0] y, input int gap);
    logic [ACC_W-1:0] e;
    logic rdy;
    int k;
    e = '0;
    for (int i = 0; i < n; i++) e = e + model(m, x, y);
    exp_q.push_back(e);
    start = 1'b1;
    mode  = m;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
    mode  = 3'($urandom);
    len   = LEN_W'($urandom);
    if (n == 0) begin
      @(negedge CLK);
      chk({tag, "_ov"}, 64'(out_valid), 64'd1);
      chk({tag, "_rdy"}, 64'(in_ready), 64'd0);
      chk({tag, "_res"}, result, 64'd0);
    end else begin
      for (int i = 0; i < n; i++) begin
        in_valid = 1'b1;
        a = x;
        b = y;
        k = 0;
        rdy = 1'b0;
        while (!rdy && k < 50) begin
          @(negedge CLK);
          rdy = in_ready;
          tick();
          k++;
        end
        if (!rdy) chk({tag, "_accept_tmo"}, 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        if (i < n - 1) begin
          for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            chk({tag, "_gap_rdy"}, 64'(in_ready), 64'd1);
            tick();
          end
        end
      end
      @(negedge CLK);
      chk({tag, "_ov_early"}, 64'(out_valid), 64'd0);
      tick();
      @(negedge CLK);
      chk({tag, "_ov_lat"}, 64'(out_valid), 64'd1);
    end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    tick();
    while (busy && k < 50) begin
      tick();
      k++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_res", result, 64'd0);
    nrst = 1'b1;
    tick();

    run_vec("int8", 3'd2, 3, 32'h1111_1111, 32'h1111_1111, 0);
    drain("int8");

    // Abort a vector mid-stream with reset.
    start = 1'b1; mode = 3'd0; len = 16'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    tick();
    tick();
    nrst = 1'b0;
    #1;
    chk("midrst_ov", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rdy", 64'(in_ready), 64'd0);
    chk("midrst_res", result, 64'd0);
    in_valid = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    run_vec("postrst", 3'd2, 1, 32'h0102_0304, 32'h0506_0708, 0);
    drain("postrst");

    run_vec("int32wrap", 3'd0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    drain("int32wrap");

    run_vec("int16gap", 3'd1, 2, 32'h2222_2222, 32'h2222_2222, 1);
    drain("int16gap");

    out_ready = 1'b0;
    run_vec("int2hold", 3'd4, 1, 32'h5555_5555, 32'h5555_5555, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ov", 64'(out_valid), 64'd1);
      chk("hold_res", result, 64'h10);
      start = (i == 2);
      mode  = 3'd2;
      len   = 16'd3;
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold_release_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_no_restart", 64'(busy), 64'd0);
    end

    run_vec("len0", 3'd3, 0, 32'h0, 32'h0, 0);
    drain("len0");

    run_vec("mode6", 3'd6, 1, 32'h0000_0002, 32'h0000_0002, 0);
    drain("mode6");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
